imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
- Writer side of the instruction-memory interface: fills the IF-stage instruction memory that the 5-stage pipeline reads.
- Accepts a byte stream over a valid/ready handshake from a host or UART front-end.
- Assembles big-endian 32-bit words and issues single-cycle write strobes into instruction memory.
- Holds the pipeline in reset via core_reset until the program is fully loaded.

Parameters:
- N, 32, instruction word width in bits; fixed multiple of 8.
- N_IMEM, 256, instruction memory depth in words.
- N_CNT, 16, width of the word-count header field in bits; fixed at 16.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte.
- reload  input  1  one-cycle pulse; restarts loading; honoured only in RUN or ERROR.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  $clog2(N_IMEM)  word address of the write.
- imem_wdata  output  N  word to write.
- core_reset  output  1  drives the pipeline reset; high until load completes.
- load_done  output  1  high in RUN.
- load_error  output  1  high in ERROR.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, or on reset release:
  - state = HDR_HI; imem_we = 0; imem_addr = 0; imem_wdata = 0.
  - core_reset = 1; load_done = 0; load_error = 0; rx_ready = 0.
  - Word counter, byte counter and count register are cleared.
- Handshake:
  - A byte is accepted on a rising edge where rx_valid && rx_ready.
  - rx_data is sampled only on accept.
  - rx_ready = 1 in HDR_HI, HDR_LO and DATA (and CSUM when the optional feature is enabled); rx_ready = 0 in RUN and ERROR.
  - rx_ready never depends combinationally on rx_valid.
- States:
  - HDR_HI: accept count[15:8], then go to HDR_LO.
  - HDR_LO: accept count[7:0], then decide:
    - count == 0 -> RUN (next cycle core_reset = 0, no writes).
    - count > N_IMEM -> ERROR.
    - otherwise -> DATA.
  - DATA:
    - Bytes are shifted into the word MSB-first: byte 0 is bits [31:24].
    - On accepting byte 3, the next cycle has imem_we = 1, imem_addr = word index, imem_wdata = assembled word.
    - The word index increments after each write.
    - Write latency is 1 cycle after the 4th byte is accepted.
    - Bytes continue to be accepted during the write cycle, so the loader sustains one byte per cycle.
    - After the write of word count-1, the next state is RUN (or CSUM with the option enabled).
  - RUN:
    - core_reset = 0; load_done = 1; imem_we = 0.
    - A reload pulse moves to HDR_HI with core_reset = 1 and load_done = 0 on the next cycle.
  - ERROR:
    - core_reset stays 1; load_error = 1.
    - Bytes are not accepted.
    - A reload pulse clears load_error and moves to HDR_HI.
- Boundary conditions:
  - rx_valid gaps, at any byte position, stall assembly without corrupting the partial word.
  - A reload pulse in HDR_HI, HDR_LO, DATA or CSUM is ignored.
  - count == N_IMEM fills addresses 0..N_IMEM-1; imem_addr never wraps.
  - Reset mid-load aborts immediately. Words already written stay in memory; the loader does not clear instruction memory.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all data bytes (header bytes excluded) is kept.
  - After the last data word, state CSUM accepts one byte.
  - Byte == running XOR -> RUN; mismatch -> ERROR.
  - For count == 0 the checksum byte is still required and must be 0x00.
- Undefined:
  - No CSUM state and no checksum logic.
  - The last data word transitions directly to RUN.

Test Plan:
- Stream 00 02 12 34 56 78 9A BC DE F0, rx_valid held high -> imem_we pulses:
  - addr 0 with 0x12345678, then addr 1 with 0x9ABCDEF0, 4 cycles apart.
  - core_reset falls 1 cycle after the second write; load_done = 1.
- Stream 00 00 -> no imem_we; RUN 1 cycle after the 2nd byte is accepted; core_reset = 0.
  - With the option enabled, 00 00 00 is required instead.
- Stream 01 01 (count 257 > 256) -> ERROR; load_error = 1; rx_ready = 0; core_reset stays 1.
  - A reload pulse then clears load_error and returns rx_ready = 1.
- Stream 00 01 AA BB CC DD with rx_valid low for 3 cycles between every byte -> exactly one write, addr 0, data 0xAABBCCDD.
- In RUN, pulse reload and stream 00 01 11 22 33 44 -> core_reset is high during the reload; addr 0 is rewritten with 0x11223344; RUN is re-entered.
- Assert reset after the 2nd data byte of word 1 -> all outputs return to reset values; a fresh 00 01 ... load then writes addr 0 correctly.
  - With the option enabled, a wrong checksum byte leads to ERROR.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Instruction-memory writer: loads a 16-bit-count-prefixed, big-endian word stream and holds the core
// in reset until the program is in place. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_stream_loader #(
   parameter int N      = 32,
   parameter int N_IMEM = 256,
   parameter int N_CNT  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      rx_ready,
   input  logic                      reload,
   output logic                      imem_we,
   output logic [$clog2(N_IMEM)-1:0] imem_addr,
   output logic [N-1:0]              imem_wdata,
   output logic                      core_reset,
   output logic                      load_done,
   output logic                      load_error
);
   localparam int ADDR_W = $clog2(N_IMEM);
   localparam int BYTES  = N / 8;
   localparam int BC_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM,
`endif
      RUN,
      ERROR
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t LOAD_END = CSUM;
`else
   localparam state_t LOAD_END = RUN;
`endif

   state_t            state, state_nx;
   logic [N_CNT-1:0]  count;
   logic [N_CNT-1:0]  word_idx;
   logic [BC_W-1:0]   byte_cnt;
   logic [N-9:0]      shift;
   logic              data_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   logic              accept;
   logic [N_CNT-1:0]  hdr_count;
   logic              last_byte;
   logic              last_word;
   logic [N-1:0]      next_word;

   assign accept    = rx_valid && rx_ready;
   assign hdr_count = {count[N_CNT-1:8], rx_data};
   assign last_byte = (byte_cnt == BC_W'(BYTES - 1));
   assign last_word = (word_idx == count - N_CNT'(1));
   assign next_word = {shift, rx_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= HDR_HI;
      else       state <= state_nx;
   end

   // data_last holds DATA for the final write cycle so RUN begins one cycle after the last strobe.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nx   = state;
      rx_ready   = 1'b0;
      core_reset = 1'b1;
      load_done  = 1'b0;
      load_error = 1'b0;
      case (state)
         HDR_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nx = HDR_LO;
         end
         HDR_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (hdr_count == '0)                     state_nx = LOAD_END;
               else if (hdr_count > N_CNT'(N_IMEM))     state_nx = ERROR;
               else                                     state_nx = DATA;
            end
         end
         DATA: begin
            rx_ready = !data_last;
            if (data_last) state_nx = LOAD_END;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nx = (rx_data == csum) ? RUN : ERROR;
         end
`endif
         RUN: begin
            core_reset = 1'b0;
            load_done  = 1'b1;
            if (reload) state_nx = HDR_HI;
         end
         ERROR: begin
            load_error = 1'b1;
            if (reload) state_nx = HDR_HI;
         end
         default: state_nx = HDR_HI;
      endcase
      if (reset) rx_ready = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   // Reset aborts the stream but never touches instruction memory; words already written remain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         data_last  <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         if (accept) begin
            case (state)
               HDR_HI: begin
                  count[N_CNT-1:8] <= rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum             <= '0;
`endif
               end
               HDR_LO: begin
                  count[7:0] <= rx_data;
                  word_idx   <= '0;
                  byte_cnt   <= '0;
                  data_last  <= 1'b0;
               end
               DATA: begin
                  shift <= next_word[N-9:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum  <= csum ^ rx_data;
`endif
                  if (last_byte) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_idx[ADDR_W-1:0];
                     imem_wdata <= next_word;
                     word_idx   <= word_idx + N_CNT'(1);
                     byte_cnt   <= '0;
                     data_last  <= last_word;
                  end else begin
                     byte_cnt <= byte_cnt + BC_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader; a write scoreboard checks every imem_we strobe against
// the words the stimulus pushed, in order.
module tb_imem_stream_loader;
   localparam int N      = 32;
   localparam int N_IMEM = 256;
   localparam int N_CNT  = 16;
   localparam int ADDR_W = $clog2(N_IMEM);

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              reload;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [N-1:0]      imem_wdata;
   logic              core_reset;
   logic              load_done;
   logic              load_error;

   typedef struct packed {
      logic [31:0]  addr;
      logic [N-1:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         tests = 0;
   int         fails = 0;
   logic [7:0] tb_csum;

   always #5 clk = ~clk;

   imem_stream_loader #(.N(N), .N_IMEM(N_IMEM), .N_CNT(N_CNT)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      wr_t e;
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(imem_addr), e.addr);
            check("wr_data", imem_wdata, e.data);
         end
      end
   end

   // Called just after a falling edge; returns on the falling edge after the byte is accepted.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited   = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      #1;
      while (rx_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (waited == 40) check("accept_timeout", 32'(rx_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_data_byte(input logic [7:0] b);
      tb_csum = tb_csum ^ b;
      send_byte(b);
   endtask

   task automatic send_word(input int addr, input logic [N-1:0] w);
      wr_t e;
      e.addr = 32'(addr);
      e.data = w;
      exp_q.push_back(e);
      for (int k = N / 8 - 1; k >= 0; k--) send_data_byte(w[k*8 +: 8]);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         rx_data = 8'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   // Brings the loader from its last data/header byte into RUN.
   task automatic finish_load(input logic empty);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(tb_csum);
`else
      if (!empty) @(negedge clk);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      reload   = 1'b0;
      tb_csum  = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_we",         32'(imem_we),    32'd0);
      check("rst_addr",       32'(imem_addr),  32'd0);
      check("rst_wdata",      imem_wdata,      32'd0);
      check("rst_core_reset", 32'(core_reset), 32'd1);
      check("rst_done",       32'(load_done),  32'd0);
      check("rst_error",      32'(load_error), 32'd0);
      check("rst_ready",      32'(rx_ready),   32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("hdr_hi_ready", 32'(rx_ready), 32'd1);

      // Two words, rx_valid held high.
      tb_csum = 8'h00;
      send_byte(8'h00);
      send_byte(8'h02);
      send_word(0, 32'h1234_5678);
      check("t1_w0_we",         32'(imem_we),    32'd1);
      check("t1_w0_core_reset", 32'(core_reset), 32'd1);
      send_word(1, 32'h9ABC_DEF0);
      check("t1_w1_we",         32'(imem_we),    32'd1);
      check("t1_w1_addr",       32'(imem_addr),  32'd1);
      check("t1_w1_ready",      32'(rx_ready),   32'd0);
      check("t1_w1_core_reset", 32'(core_reset), 32'd1);
      finish_load(1'b0);
      check("t1_run_core_reset", 32'(core_reset), 32'd0);
      check("t1_run_done",       32'(load_done),  32'd1);
      check("t1_run_we",         32'(imem_we),    32'd0);
      check("t1_hold_addr",      32'(imem_addr),  32'd1);
      check("t1_hold_wdata",     imem_wdata,      32'h9ABC_DEF0);
      check("t1_drain",          32'(exp_q.size()), 32'd0);

      // Reload from RUN and overwrite address 0.
      pulse_reload();
      check("t5_reload_core_reset", 32'(core_reset), 32'd1);
      check("t5_reload_done",       32'(load_done),  32'd0);
      check("t5_reload_ready",      32'(rx_ready),   32'd1);
      tb_csum = 8'h00;
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(0, 32'h1122_3344);
      check("t5_we", 32'(imem_we), 32'd1);
      finish_load(1'b0);
      check("t5_done",       32'(load_done),  32'd1);
      check("t5_core_reset", 32'(core_reset), 32'd0);
      check("t5_drain",      32'(exp_q.size()), 32'd0);

      // Empty program.
      pulse_reload();
      tb_csum = 8'h00;
      send_byte(8'h00);
      send_byte(8'h00);
      finish_load(1'b1);
      check("t2_done",       32'(load_done),  32'd1);
      check("t2_core_reset", 32'(core_reset), 32'd0);
      check("t2_we",         32'(imem_we),    32'd0);
      check("t2_hold_addr",  32'(imem_addr),  32'd0);
      check("t2_hold_wdata", imem_wdata,      32'h1122_3344);

      // Oversized count goes to ERROR.
      pulse_reload();
      send_byte(8'h01);
      send_byte(8'h01);
      check("t3_error",      32'(load_error), 32'd1);
      check("t3_ready",      32'(rx_ready),   32'd0);
      check("t3_core_reset", 32'(core_reset), 32'd1);
      check("t3_done",       32'(load_done),  32'd0);
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("t3_error_sticky", 32'(load_error), 32'd1);
      pulse_reload();
      check("t3_reload_error", 32'(load_error), 32'd0);
      check("t3_reload_ready", 32'(rx_ready),   32'd1);

      // Three idle cycles between every byte; a reload inside DATA must be ignored.
      tb_csum = 8'h00;
      send_byte(8'h00);
      idle(3);
      send_byte(8'h01);
      idle(3);
      begin
         wr_t e;
         e.addr = 32'd0;
         e.data = 32'hAABB_CCDD;
         exp_q.push_back(e);
      end
      send_data_byte(8'hAA);
      idle(1);
      pulse_reload();
      idle(1);
      send_data_byte(8'hBB);
      idle(3);
      send_data_byte(8'hCC);
      idle(3);
      check("t4_gap_no_we", 32'(imem_we), 32'd0);
      send_data_byte(8'hDD);
      check("t4_we",    32'(imem_we),   32'd1);
      check("t4_addr",  32'(imem_addr), 32'd0);
      finish_load(1'b0);
      check("t4_done",  32'(load_done), 32'd1);
      check("t4_drain", 32'(exp_q.size()), 32'd0);

      // Full memory: addresses 0..N_IMEM-1 with no wrap.
      pulse_reload();
      tb_csum = 8'h00;
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < N_IMEM; i++)
         send_word(i, {8'(i), ~8'(i), 8'(i * 7), 8'hA5});
      check("full_last_addr", 32'(imem_addr), 32'(N_IMEM - 1));
      finish_load(1'b0);
      check("full_done",  32'(load_done), 32'd1);
      check("full_drain", 32'(exp_q.size()), 32'd0);

      // Reset after the 2nd data byte of word 1.
      pulse_reload();
      tb_csum = 8'h00;
      send_byte(8'h00);
      send_byte(8'h02);
      send_word(0, 32'hCAFE_BABE);
      send_data_byte(8'h01);
      send_data_byte(8'h02);
      reset = 1'b1;
      #1;
      check("t6_rst_we",         32'(imem_we),    32'd0);
      check("t6_rst_addr",       32'(imem_addr),  32'd0);
      check("t6_rst_wdata",      imem_wdata,      32'd0);
      check("t6_rst_core_reset", 32'(core_reset), 32'd1);
      check("t6_rst_done",       32'(load_done),  32'd0);
      check("t6_rst_error",      32'(load_error), 32'd0);
      check("t6_rst_ready",      32'(rx_ready),   32'd0);
      check("t6_rst_drain",      32'(exp_q.size()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tb_csum = 8'h00;
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(0, 32'h5566_7788);
      check("t6_we", 32'(imem_we), 32'd1);
      finish_load(1'b0);
      check("t6_done",  32'(load_done), 32'd1);
      check("t6_drain", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Wrong checksum byte.
      pulse_reload();
      tb_csum = 8'h00;
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(0, 32'h0BAD_F00D);
      send_byte(tb_csum ^ 8'h5A);
      check("csum_bad_error",      32'(load_error), 32'd1);
      check("csum_bad_core_reset", 32'(core_reset), 32'd1);
      check("csum_bad_drain",      32'(exp_q.size()), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
